// File: rtl/core_pkg.sv
// Shared core definitions: fetch buffer entry layout and instruction size.
package core_pkg;

    localparam int unsigned CORE_XLEN   = 32;
    localparam int unsigned INSTR_BYTES = 4;

    typedef struct packed {
        logic [CORE_XLEN-1:0] instr;
        logic [CORE_XLEN-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small circular FIFO with a synchronous clear; holds either fetch entries
// or the PCs of in-flight requests.
module fetch_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter type         T     = logic [31:0]
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clr_i,
    input  logic                         push_i,
    input  T                             push_data_i,
    input  logic                         pop_i,
    output T                             head_o,
    output logic                         empty_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    T              mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          full;
    logic          do_push;
    logic          do_pop;

    assign empty_o = (cnt_q == '0);
    assign full    = (cnt_q == CW'(DEPTH));
    assign count_o = cnt_q;
    assign head_o  = mem_q[rd_ptr_q];

    // A push into a full FIFO is legal when the head leaves in the same cycle.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (clr_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   cnt_d = cnt_q + CW'(1);
                2'b01:   cnt_d = cnt_q - CW'(1);
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !clr_i) mem_q[wr_ptr_q] <= push_data_i;
    end

endmodule

// File: rtl/stage_fetch_buf.sv
// Instruction fetch stage: issues sequential word fetches, buffers in-order
// responses tagged with their PC, and flushes on redirect. XLEN must equal CORE_XLEN.
module stage_fetch_buf
    import core_pkg::*;
#(
    parameter int unsigned     XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000,
    parameter int unsigned     DEPTH        = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_instr,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_addr,
    output logic            fetch_valid,
    input  logic            fetch_ready,
    output logic [XLEN-1:0] fetch_instr,
    output logic [XLEN-1:0] fetch_instr_addr,
    output logic [XLEN-1:0] fetch_instr_addr_plus
);

    localparam int unsigned CW      = $clog2(DEPTH + 1);
    localparam int unsigned DW      = CW + 4;
    localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

    logic [XLEN-1:0] pc_q, pc_d;
    logic [DW-1:0]   disc_q, disc_d;
    logic [DW-1:0]   inflight;
    logic [CW-1:0]   out_cnt;
    logic [CW-1:0]   buf_cnt;
    logic [XLEN-1:0] pcq_head;
    logic            pcq_empty;
    logic            buf_empty;
    logic            accept;
    logic            rsp_take;
    logic            rsp_drop;
    logic            buf_pop;
    fetch_entry_t    rsp_entry;
    fetch_entry_t    buf_head;

    // The PC queue occupancy doubles as the outstanding-request counter:
    // it grows on each accepted request and shrinks on each kept response.
    fetch_fifo #(
        .DEPTH (DEPTH),
        .T     (logic [XLEN-1:0])
    ) u_pc_queue (
        .clk         (clk),
        .rst_n       (rst_n),
        .clr_i       (redirect_valid),
        .push_i      (accept),
        .push_data_i (pc_q),
        .pop_i       (rsp_take),
        .head_o      (pcq_head),
        .empty_o     (pcq_empty),
        .count_o     (out_cnt)
    );

    fetch_fifo #(
        .DEPTH (DEPTH),
        .T     (fetch_entry_t)
    ) u_fetch_buf (
        .clk         (clk),
        .rst_n       (rst_n),
        .clr_i       (redirect_valid),
        .push_i      (rsp_take),
        .push_data_i (rsp_entry),
        .pop_i       (buf_pop),
        .head_o      (buf_head),
        .empty_o     (buf_empty),
        .count_o     (buf_cnt)
    );

    // Requests are gated by rst_n so the port drops to 0 the instant reset asserts.
    assign imem_req_valid = rst_n && !redirect_valid &&
                            (({1'b0, out_cnt} + {1'b0, buf_cnt}) < DEPTH_W);
    assign imem_req_addr  = imem_req_valid ? pc_q : '0;
    assign accept         = imem_req_valid && imem_req_ready;

    assign rsp_drop  = imem_rsp_valid && (disc_q != '0);
    assign rsp_take  = imem_rsp_valid && !redirect_valid && (disc_q == '0) && !pcq_empty;
    assign rsp_entry = '{instr: imem_rsp_instr, pc: pcq_head};

    assign fetch_valid           = !buf_empty && !redirect_valid;
    assign buf_pop               = fetch_valid && fetch_ready;
    assign fetch_instr           = fetch_valid ? buf_head.instr : '0;
    assign fetch_instr_addr      = fetch_valid ? buf_head.pc : '0;
    assign fetch_instr_addr_plus = fetch_valid ? buf_head.pc + XLEN'(INSTR_BYTES) : '0;

    // On redirect every request still in flight, kept or already doomed, becomes
    // a discard, less the one response that lands in the redirect cycle itself.
    always_comb begin
        pc_d     = pc_q;
        disc_d   = disc_q;
        inflight = disc_q + DW'(out_cnt);
        if (redirect_valid) begin
            pc_d   = redirect_addr & ~XLEN'(INSTR_BYTES - 1);
            disc_d = (imem_rsp_valid && (inflight != '0)) ? inflight - DW'(1) : inflight;
        end else begin
            if (accept)   pc_d   = pc_q + XLEN'(INSTR_BYTES);
            if (rsp_drop) disc_d = disc_q - DW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q   <= RESET_VECTOR;
            disc_q <= '0;
        end else begin
            pc_q   <= pc_d;
            disc_q <= disc_d;
        end
    end

endmodule
